if_id_stall_control: RTL and testbench
======================================

IF_ID_STALL_CONTROL -- requirements
Module: if_id_stall_control

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of ip_clk.
REQ-002 ip_clk  input  1  system clock.
REQ-003 ip_reset  input  1  synchronous active-high reset.
REQ-004 ip_Hazard_Stall  input  1  load-use stall request from hazard detection: hold PC and IF/ID, bubble ID/EX.
REQ-005 ip_PC_Hold  input  1  hold-PC request from hazard detection; ORed with ip_Hazard_Stall for the PC.
REQ-006 ip_Branch_Taken  input  1  branch/jump resolved taken in ID.
REQ-007 ip_Branch_Target  input  32  redirect address.
REQ-008 ip_IMem_Ready  input  1  instruction memory returns valid ip_IMem_Data this cycle.
REQ-009 ip_IMem_Data  input  32  fetched instruction.
REQ-010 op_PC  output  32  current fetch address to instruction memory.
REQ-011 op_IF_ID_Instr / op_IF_ID_PC  output  32/32  IF/ID pipeline register contents.
REQ-012 op_IF_ID_Valid  output  1  IF/ID holds a real instruction.
REQ-013 op_ID_EX_Bubble  output  1  zero the ID/EX control fields this cycle.
REQ-014 op_State  output  2  FSM state (RUN=0, STALL=1, FLUSH=2).
REQ-015 op_Stall_Count / op_Flush_Count  output  16/16  saturating event counters.

Function
REQ-016 Hold = ip_Hazard_Stall | ip_PC_Hold | !ip_IMem_Ready; when Hold is 1, op_PC SHALL keep its value.
REQ-017 When Hold is 0 and no redirect occurs, op_PC SHALL advance by 4 per cycle, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-018 Redirect = ip_Branch_Taken & !ip_Hazard_Stall.
REQ-019 On redirect, op_PC SHALL load {ip_Branch_Target[31:2],2'b00} on the next edge, regardless of ip_PC_Hold or ip_IMem_Ready.
REQ-020 Stall takes priority: ip_Branch_Taken is ignored in any cycle where ip_Hazard_Stall=1.
REQ-021 When ip_Hazard_Stall=1, the IF/ID register SHALL hold all fields, and op_ID_EX_Bubble SHALL be 1 combinationally in the same cycle.
REQ-022 On redirect, IF/ID SHALL load NOP 0x0000_0013 with Valid=0 (flush of the wrong-path fetch).
REQ-023 With no stall, no redirect and ip_IMem_Ready=0, IF/ID SHALL load NOP with Valid=0.
REQ-024 Otherwise IF/ID SHALL load Instr=ip_IMem_Data, PC=op_PC, Valid=1; latency from fetch to IF/ID is one cycle.
REQ-025 FSM from RUN: redirect -> FLUSH; else ip_Hazard_Stall -> STALL; else RUN.
REQ-026 FSM from STALL: ip_Hazard_Stall -> STALL; else redirect -> FLUSH; else RUN.
REQ-027 FSM from FLUSH: exactly one cycle, then the RUN rules apply; a redirect while in FLUSH SHALL re-enter FLUSH.
REQ-028 op_Stall_Count SHALL increment on each cycle ip_Hazard_Stall=1.
REQ-029 op_Flush_Count SHALL increment on each redirect.
REQ-030 Both counters SHALL saturate at 0xFFFF.

Reset
REQ-031 On reset: op_PC=0x0000_0000, op_IF_ID_Instr=0x0000_0013, op_IF_ID_PC=0, op_IF_ID_Valid=0, op_State=RUN, counters=0.
REQ-032 op_ID_EX_Bubble SHALL be 1 while ip_reset=1.
REQ-033 Reset SHALL override stall, redirect and memory-ready in the same cycle.
REQ-034 Reset asserted mid-stall or mid-flush SHALL drop any pending hold or redirect.

Structure
REQ-035 A shared package rv32i_pkg SHALL hold: NOP constant 0x0000_0013, RESET_PC, PC_STEP=4, and the FSM state encoding.
REQ-036 A single sub-module sat_counter SHALL be instantiated twice for the 16-bit counters: parameterised width, inc, sync reset.
REQ-037 The IF/ID register and the PC SHALL live in this block, not in the sub-module.

Verification
REQ-038 Reset, then 3 cycles ready=1, data=0xA,0xB,0xC -> op_PC 0,4,8,12; IF/ID gets (0xA,PC 0),(0xB,PC 4),(0xC,PC 8); Valid=1.
REQ-039 ip_Hazard_Stall high 2 cycles at op_PC=0x10 -> op_PC stays 0x10, IF/ID frozen, Bubble=1 both cycles, State=STALL, op_Stall_Count=2.
REQ-040 Branch taken, target 0x103 -> op_PC=0x100 next cycle, IF/ID=NOP with Valid=0, State=FLUSH for 1 cycle, op_Flush_Count=1.
REQ-041 Branch taken together with ip_Hazard_Stall -> no redirect, PC held, op_Flush_Count unchanged; when the stall drops with the branch still asserted -> redirect occurs.
REQ-042 Edge cases: ip_IMem_Ready=0 with op_PC=0xFFFF_FFFC -> PC held and IF/ID=NOP; when ready returns -> PC wraps to 0. Preloaded op_Stall_Count=0xFFFF plus a stall -> stays 0xFFFF.
REQ-043 Reset asserted in the middle of a stall -> all outputs take the REQ-031 values on the next edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants and types for the IF/ID stall/flush control slice.
package rv32i_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'h0000_0004;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  // Redirect targets are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             ip_clk,
  input  logic             ip_reset,
  input  logic             ip_inc,
  output logic [WIDTH-1:0] op_count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (ip_inc && (r_count != {WIDTH{1'b1}})) begin
      w_count_next = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_count_next = r_count;
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_reset) begin
      r_count <= {WIDTH{1'b0}};
    end else begin
      r_count <= w_count_next;
    end
  end

  assign op_count = r_count;

endmodule

// File: rtl/if_id_stall_control.sv
// Fetch-side control: PC, IF/ID register, stall/flush FSM and event counters.
module if_id_stall_control
  import rv32i_pkg::*;
(
  input  logic        ip_clk,
  input  logic        ip_reset,
  input  logic        ip_Hazard_Stall,
  input  logic        ip_PC_Hold,
  input  logic        ip_Branch_Taken,
  input  logic [31:0] ip_Branch_Target,
  input  logic        ip_IMem_Ready,
  input  logic [31:0] ip_IMem_Data,
  output logic [31:0] op_PC,
  output logic [31:0] op_IF_ID_Instr,
  output logic [31:0] op_IF_ID_PC,
  output logic        op_IF_ID_Valid,
  output logic        op_ID_EX_Bubble,
  output logic [1:0]  op_State,
  output logic [15:0] op_Stall_Count,
  output logic [15:0] op_Flush_Count
);

  logic [31:0] r_pc;
  if_id_t      r_if_id;
  logic [1:0]  r_state;

  logic        w_hold;
  logic        w_redirect;
  logic [31:0] w_pc_next;
  if_id_t      w_if_id_next;
  logic [1:0]  w_state_next;

  // A hazard stall masks any branch resolved in the same cycle.
  assign w_hold     = ip_Hazard_Stall | ip_PC_Hold | ~ip_IMem_Ready;
  assign w_redirect = ip_Branch_Taken & ~ip_Hazard_Stall;

  always_comb begin
    w_pc_next = r_pc;
    if (w_redirect) begin
      w_pc_next = align_pc(ip_Branch_Target);
    end else if (w_hold) begin
      w_pc_next = r_pc;
    end else begin
      w_pc_next = r_pc + PC_STEP;
    end
  end

  always_comb begin
    w_if_id_next = r_if_id;
    if (ip_Hazard_Stall) begin
      w_if_id_next = r_if_id;
    end else if (w_redirect || !ip_IMem_Ready) begin
      w_if_id_next = '{instr: NOP, pc: r_pc, valid: 1'b0};
    end else begin
      w_if_id_next = '{instr: ip_IMem_Data, pc: r_pc, valid: 1'b1};
    end
  end

  // FLUSH lasts one cycle and then follows the RUN rules.
  always_comb begin
    w_state_next = ST_RUN;
    case (r_state)
      ST_RUN, ST_FLUSH: begin
        if (w_redirect) begin
          w_state_next = ST_FLUSH;
        end else if (ip_Hazard_Stall) begin
          w_state_next = ST_STALL;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_STALL: begin
        if (ip_Hazard_Stall) begin
          w_state_next = ST_STALL;
        end else if (w_redirect) begin
          w_state_next = ST_FLUSH;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge ip_clk) begin
    if (ip_reset) begin
      r_pc    <= RESET_PC;
      r_if_id <= '{instr: NOP, pc: 32'h0000_0000, valid: 1'b0};
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_next;
      r_if_id <= w_if_id_next;
      r_state <= w_state_next;
    end
  end

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .ip_clk   (ip_clk),
    .ip_reset (ip_reset),
    .ip_inc   (ip_Hazard_Stall),
    .op_count (op_Stall_Count)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .ip_clk   (ip_clk),
    .ip_reset (ip_reset),
    .ip_inc   (w_redirect),
    .op_count (op_Flush_Count)
  );

  assign op_PC           = r_pc;
  assign op_IF_ID_Instr  = r_if_id.instr;
  assign op_IF_ID_PC     = r_if_id.pc;
  assign op_IF_ID_Valid  = r_if_id.valid;
  assign op_State        = r_state;
  // Bubble must react in the same cycle as the stall, so it is not registered.
  assign op_ID_EX_Bubble = ip_reset | ip_Hazard_Stall;

endmodule

// File: tb/tb_if_id_stall_control.sv
// Directed bench with a cycle-level reference model and literal pins.
module tb_if_id_stall_control;

  logic        clk = 1'b0;
  logic        s_reset = 1'b1, s_stall = 1'b0, s_pch = 1'b0, s_br = 1'b0, s_rdy = 1'b0;
  logic [31:0] s_tgt = 32'h0, s_data = 32'h0;

  logic [31:0] pc, if_instr, if_pc;
  logic        if_valid, bubble;
  logic [1:0]  state;
  logic [15:0] scnt, fcnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state (plain integers, updated from the rules at each edge).
  longint m_pc = 0, m_instr = 32'h13, m_ifpc = 0;
  int     m_valid = 0, m_st = 0, m_sc = 0, m_fc = 0;

  always #5 clk = ~clk;

  if_id_stall_control dut (
    .ip_clk(clk), .ip_reset(s_reset), .ip_Hazard_Stall(s_stall), .ip_PC_Hold(s_pch),
    .ip_Branch_Taken(s_br), .ip_Branch_Target(s_tgt), .ip_IMem_Ready(s_rdy),
    .ip_IMem_Data(s_data), .op_PC(pc), .op_IF_ID_Instr(if_instr), .op_IF_ID_PC(if_pc),
    .op_IF_ID_Valid(if_valid), .op_ID_EX_Bubble(bubble), .op_State(state),
    .op_Stall_Count(scnt), .op_Flush_Count(fcnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit     redirect, hold;
    longint npc;
    redirect = s_br && !s_stall;
    hold     = s_stall || s_pch || !s_rdy;
    if (s_reset) begin
      m_pc = 0; m_instr = 32'h13; m_ifpc = 0; m_valid = 0; m_st = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (redirect)  npc = s_tgt - (s_tgt % 4);
      else if (hold) npc = m_pc;
      else           npc = (m_pc + 4) % 64'h1_0000_0000;
      if (s_stall) begin
        // IF/ID frozen
      end else if (redirect || !s_rdy) begin
        m_instr = 32'h13; m_valid = 0; m_ifpc = m_pc;
      end else begin
        m_instr = s_data; m_valid = 1; m_ifpc = m_pc;
      end
      m_st = redirect ? 2 : (s_stall ? 1 : 0);
      if (s_stall  && m_sc < 65535) m_sc++;
      if (redirect && m_fc < 65535) m_fc++;
      m_pc = npc;
    end
  endtask

  // Every cycle: registered outputs vs model, bubble vs current inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("if_instr", if_instr, m_instr);
      chk("if_valid", if_valid, m_valid);
      if (m_valid == 1) chk("if_pc", if_pc, m_ifpc);
      chk("state", state, m_st);
      chk("stall_cnt", scnt, m_sc);
      chk("flush_cnt", fcnt, m_fc);
      chk("bubble", bubble, (s_stall || s_reset) ? 1 : 0);
    end
  end

  task automatic cycle(input logic rst, input logic stall, input logic pch, input logic br,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] data);
    s_reset = rst; s_stall = stall; s_pch = pch; s_br = br; s_tgt = tgt;
    s_rdy = rdy; s_data = data;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic pin(input string name, input longint dut_v, input longint mdl_v, input longint lit);
    chk({name, "_dut"}, dut_v, lit);
    chk({name, "_model"}, mdl_v, lit);
  endtask

  initial begin
    @(posedge clk); #2;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    pin("rst_pc", pc, m_pc, 0);
    pin("rst_instr", if_instr, m_instr, 32'h13);
    chk("rst_ifpc", if_pc, 0);
    pin("rst_valid", if_valid, m_valid, 0);

    // sequential fetch A,B,C
    cycle(0, 0, 0, 0, 0, 1, 32'hA);
    cycle(0, 0, 0, 0, 0, 1, 32'hB);
    cycle(0, 0, 0, 0, 0, 1, 32'hC);
    pin("seq_pc", pc, m_pc, 12);
    pin("seq_instr", if_instr, m_instr, 32'hC);
    pin("seq_ifpc", if_pc, m_ifpc, 8);
    pin("seq_valid", if_valid, m_valid, 1);

    // load-use stall at PC 0x10
    cycle(0, 0, 0, 0, 0, 1, 32'hD);
    cycle(0, 1, 0, 0, 0, 1, 32'hE0);
    cycle(0, 1, 0, 0, 0, 1, 32'hE1);
    pin("stall_pc", pc, m_pc, 32'h10);
    pin("stall_instr", if_instr, m_instr, 32'hD);
    pin("stall_ifpc", if_pc, m_ifpc, 32'hC);
    pin("stall_state", state, m_st, 1);
    pin("stall_cnt2", scnt, m_sc, 2);
    cycle(0, 0, 0, 0, 0, 1, 32'hE);

    // taken branch to 0x103
    cycle(0, 0, 0, 1, 32'h103, 1, 32'hF);
    pin("br_pc", pc, m_pc, 32'h100);
    pin("br_instr", if_instr, m_instr, 32'h13);
    pin("br_valid", if_valid, m_valid, 0);
    pin("br_state", state, m_st, 2);
    pin("br_fcnt", fcnt, m_fc, 1);
    cycle(0, 0, 0, 0, 0, 1, 32'h11);
    pin("postbr_state", state, m_st, 0);

    // branch masked by stall, then taken when the stall drops
    cycle(0, 1, 0, 1, 32'h200, 1, 32'h12);
    pin("mask_pc", pc, m_pc, 32'h104);
    pin("mask_fcnt", fcnt, m_fc, 1);
    cycle(0, 0, 0, 1, 32'h200, 1, 32'h13);
    pin("unmask_pc", pc, m_pc, 32'h200);
    pin("unmask_fcnt", fcnt, m_fc, 2);
    cycle(0, 0, 0, 1, 32'h300, 1, 32'h14);
    pin("reflush_state", state, m_st, 2);
    pin("reflush_pc", pc, m_pc, 32'h300);

    // PC_Hold and not-ready behaviour, redirect overriding both
    cycle(0, 0, 1, 0, 0, 1, 32'h15);
    pin("pchold_pc", pc, m_pc, 32'h300);
    pin("pchold_instr", if_instr, m_instr, 32'h15);
    cycle(0, 0, 0, 0, 0, 0, 32'h16);
    pin("nrdy_instr", if_instr, m_instr, 32'h13);
    cycle(0, 0, 1, 1, 32'hFFFF_FFFF, 0, 32'h17);
    pin("redir_hold_pc", pc, m_pc, 32'hFFFF_FFFC);

    // wrap at top of address space
    cycle(0, 0, 0, 0, 0, 0, 32'h18);
    pin("wrap_hold_pc", pc, m_pc, 32'hFFFF_FFFC);
    pin("wrap_hold_valid", if_valid, m_valid, 0);
    cycle(0, 0, 0, 0, 0, 1, 32'h19);
    pin("wrap_pc", pc, m_pc, 0);
    pin("wrap_ifpc", if_pc, m_ifpc, 32'hFFFF_FFFC);

    // reset in the middle of a stall with a branch pending
    cycle(0, 1, 0, 0, 0, 1, 32'h1A);
    cycle(1, 1, 1, 1, 32'h400, 1, 32'h1B);
    pin("midrst_pc", pc, m_pc, 0);
    pin("midrst_instr", if_instr, m_instr, 32'h13);
    pin("midrst_state", state, m_st, 0);
    pin("midrst_scnt", scnt, m_sc, 0);
    pin("midrst_fcnt", fcnt, m_fc, 0);

    // stall counter saturation
    for (int i = 0; i < 65537; i++) cycle(0, 1, 0, 0, 0, 1, 32'h1C);
    pin("sat_scnt", scnt, m_sc, 32'hFFFF);
    cycle(0, 1, 0, 0, 0, 1, 32'h1D);
    pin("sat_hold", scnt, m_sc, 32'hFFFF);
    cycle(0, 0, 0, 0, 0, 1, 32'h1E);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
